// File: rtl/mc_datapath_if.sv
// Control, memory and decode bundle between a multicycle controller and mc_datapath.
// The master side drives controls and read data; the slave (datapath) returns address, store data and decode fields.
interface mc_datapath_if #(
    parameter int XLen = 32
);
    logic            pc_write_i;
    logic            addr_src_i;
    logic            mem_write_i;
    logic            ir_write_i;
    logic            reg_write_i;
    logic [1:0]      result_src_i;
    logic [2:0]      alu_control_i;
    logic [1:0]      alu_src_a_i;
    logic [1:0]      alu_src_b_i;
    logic [2:0]      imm_src_i;

    logic [XLen-1:0] mem_addr_o;
    logic [XLen-1:0] mem_wdata_o;
    logic            mem_we_o;
    logic [XLen-1:0] mem_rdata_i;

    logic [6:0]      op_o;
    logic [2:0]      funct3_o;
    logic            funct7_o;
    logic            zero_o;

    modport master (
        output pc_write_i, addr_src_i, mem_write_i, ir_write_i, reg_write_i,
        output result_src_i, alu_control_i, alu_src_a_i, alu_src_b_i, imm_src_i,
        output mem_rdata_i,
        input  mem_addr_o, mem_wdata_o, mem_we_o,
        input  op_o, funct3_o, funct7_o, zero_o
    );

    modport slave (
        input  pc_write_i, addr_src_i, mem_write_i, ir_write_i, reg_write_i,
        input  result_src_i, alu_control_i, alu_src_a_i, alu_src_b_i, imm_src_i,
        input  mem_rdata_i,
        output mem_addr_o, mem_wdata_o, mem_we_o,
        output op_o, funct3_o, funct7_o, zero_o
    );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle RISC-V style datapath: PC/OldPC/IR/Data/A/B/ALUOut registers, 32-entry register file, ALU and immediates.
// Optional macro DATAPATH_SLT_EN adds the signed set-less-than ALU operation (code 101).
module mc_datapath #(
    parameter int              XLen    = 32,
    parameter logic [XLen-1:0] ResetPc = 32'h0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mc_datapath_if.slave bus
);
    logic [XLen-1:0] pc_reg;
    logic [XLen-1:0] old_pc_reg;
    logic [31:0]     ir_reg;
    logic [XLen-1:0] data_reg;
    logic [XLen-1:0] a_reg;
    logic [XLen-1:0] b_reg;
    logic [XLen-1:0] alu_out_reg;
    logic [XLen-1:0] rf_reg [32];

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLen-1:0] rs1_data;
    logic [XLen-1:0] rs2_data;
    logic [XLen-1:0] src_a;
    logic [XLen-1:0] src_b;
    logic [XLen-1:0] alu_result;
    logic [31:0]     imm32;
    logic [XLen-1:0] imm_ext;
    logic [XLen-1:0] result;

    assign rs1 = ir_reg[19:15];
    assign rs2 = ir_reg[24:20];
    assign rd  = ir_reg[11:7];

    // x0 is hardwired to zero on read; its storage is never written.
    assign rs1_data = (rs1 == 5'd0) ? '0 : rf_reg[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : rf_reg[rs2];

    always_comb begin
        imm32 = '0;
        case (bus.imm_src_i)
            3'b000:  imm32 = {{20{ir_reg[31]}}, ir_reg[31:20]};
            3'b001:  imm32 = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
            3'b010:  imm32 = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25],
                              ir_reg[11:8], 1'b0};
            3'b011:  imm32 = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20],
                              ir_reg[30:21], 1'b0};
            3'b100:  imm32 = {ir_reg[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = XLen'($signed(imm32));

    always_comb begin
        src_a = '0;
        case (bus.alu_src_a_i)
            2'b00:   src_a = pc_reg;
            2'b01:   src_a = old_pc_reg;
            2'b10:   src_a = a_reg;
            default: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (bus.alu_src_b_i)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = XLen'(4);
            default: src_b = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (bus.alu_control_i)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
`ifdef DATAPATH_SLT_EN
            3'b101:  alu_result = XLen'($signed(src_a) < $signed(src_b));
`endif
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (bus.result_src_i)
            2'b00:   result = alu_out_reg;
            2'b01:   result = data_reg;
            2'b10:   result = alu_result;
            default: result = imm_ext;
        endcase
    end

    // OldPC captures the pre-edge PC even when PC is written in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_reg      <= ResetPc;
            old_pc_reg  <= '0;
            ir_reg      <= '0;
            data_reg    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
        end else begin
            if (bus.pc_write_i) begin
                pc_reg <= result;
            end
            if (bus.ir_write_i) begin
                ir_reg     <= bus.mem_rdata_i[31:0];
                old_pc_reg <= pc_reg;
            end
            data_reg    <= bus.mem_rdata_i;
            a_reg       <= rs1_data;
            b_reg       <= rs2_data;
            alu_out_reg <= alu_result;
        end
    end

    // Reads are asynchronous, so a same-cycle read of the written register sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (bus.reg_write_i && (rd != 5'd0)) begin
            rf_reg[rd] <= result;
        end
    end

    assign bus.mem_addr_o  = bus.addr_src_i ? result : pc_reg;
    assign bus.mem_wdata_o = b_reg;
    assign bus.mem_we_o    = bus.mem_write_i;
    assign bus.op_o        = ir_reg[6:0];
    assign bus.funct3_o    = ir_reg[14:12];
    assign bus.funct7_o    = ir_reg[30];
    assign bus.zero_o      = (alu_result == '0);
endmodule

// File: tb/tb_mc_datapath.sv
// Directed self-checking bench for mc_datapath: reset, fetch, execute/writeback, x0, branch compare, ALU ops, immediates.
// Registers are observed through mem_addr_o by routing them through the ALU with addr_src=1.
module tb_mc_datapath;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mc_datapath_if #(.XLen(32)) bus ();

    mc_datapath #(.XLen(32), .ResetPc(32'h0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.pc_write_i    = 1'b0;
        bus.addr_src_i    = 1'b0;
        bus.mem_write_i   = 1'b0;
        bus.ir_write_i    = 1'b0;
        bus.reg_write_i   = 1'b0;
        bus.result_src_i  = 2'b00;
        bus.alu_control_i = 3'b000;
        bus.alu_src_a_i   = 2'b00;
        bus.alu_src_b_i   = 2'b00;
        bus.imm_src_i     = 3'b000;
        bus.mem_rdata_i   = 32'h0;
    endtask

    // Route srcA/srcB through the ALU onto mem_addr_o.
    task automatic show_alu(input logic [1:0] a_sel, input logic [1:0] b_sel, input logic [2:0] op);
        bus.alu_src_a_i   = a_sel;
        bus.alu_src_b_i   = b_sel;
        bus.alu_control_i = op;
        bus.result_src_i  = 2'b10;
        bus.addr_src_i    = 1'b1;
        #1;
    endtask

    task automatic load_ir(input logic [31:0] instr);
        idle();
        bus.mem_rdata_i = instr;
        bus.ir_write_i  = 1'b1;
        tick();
        idle();
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'd0, 7'h33};
    endfunction

    task automatic write_reg(input logic [4:0] rd, input logic [11:0] imm);
        load_ir(addi(rd, 5'd0, imm));
        bus.imm_src_i    = 3'b000;
        bus.result_src_i = 2'b11;
        bus.reg_write_i  = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_regs(input logic [4:0] rs1, input logic [4:0] rs2);
        load_ir(rtype(rs1, rs2));
        tick();
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        bus.mem_rdata_i = 32'h1234_5678;
        tick();
        tick();
        #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.mem_addr_o, 32'h0); end
        checks++; if (bus.op_o !== 7'h0) begin errors++; $display("FAIL reset_op got %h want %h", bus.op_o, 7'h0); end
        checks++; if ({bus.funct3_o, bus.funct7_o} !== 4'h0) begin errors++; $display("FAIL reset_funct got %h want %h", {bus.funct3_o, bus.funct7_o}, 4'h0); end
        checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_b got %h want %h", bus.mem_wdata_o, 32'h0); end
        bus.result_src_i = 2'b01; bus.addr_src_i = 1'b1; #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", bus.mem_addr_o, 32'h0); end
        bus.result_src_i = 2'b00; #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_aluout got %h want %h", bus.mem_addr_o, 32'h0); end
        show_alu(2'b10, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_a got %h want %h", bus.mem_addr_o, 32'h0); end
        idle();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fetch;
        idle();
        bus.mem_rdata_i   = 32'h00A0_0093;
        bus.ir_write_i    = 1'b1;
        bus.alu_src_a_i   = 2'b00;
        bus.alu_src_b_i   = 2'b10;
        bus.alu_control_i = 3'b000;
        bus.result_src_i  = 2'b10;
        bus.pc_write_i    = 1'b1;
        #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL fetch_addr got %h want %h", bus.mem_addr_o, 32'h0); end
        tick();
        idle();
        #1;
        checks++; if (bus.op_o !== 7'h13) begin errors++; $display("FAIL fetch_op got %h want %h", bus.op_o, 7'h13); end
        checks++; if (bus.mem_addr_o !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h want %h", bus.mem_addr_o, 32'h4); end
        show_alu(2'b01, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL fetch_oldpc got %h want %h", bus.mem_addr_o, 32'h0); end
        idle();
        $display("test_fetch done");
    endtask

    task automatic test_exec_wb;
        idle();
        bus.imm_src_i = 3'b000;
        show_alu(2'b10, 2'b01, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'd10) begin errors++; $display("FAIL exec_alu got %h want %h", bus.mem_addr_o, 32'd10); end
        checks++; if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL exec_zero got %b want %b", bus.zero_o, 1'b0); end
        tick();
        bus.result_src_i = 2'b00;
        bus.reg_write_i  = 1'b1;
        #1;
        checks++; if (bus.mem_addr_o !== 32'd10) begin errors++; $display("FAIL wb_aluout got %h want %h", bus.mem_addr_o, 32'd10); end
        tick();
        idle();
        load_ir(32'h0010_2023);
        tick();
        bus.mem_write_i = 1'b1;
        #1;
        checks++; if (bus.funct3_o !== 3'd2) begin errors++; $display("FAIL sw_funct3 got %h want %h", bus.funct3_o, 3'd2); end
        checks++; if (bus.mem_wdata_o !== 32'd10) begin errors++; $display("FAIL sw_wdata got %h want %h", bus.mem_wdata_o, 32'd10); end
        checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL sw_we got %b want %b", bus.mem_we_o, 1'b1); end
        idle();
        #1;
        checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sw_we_low got %b want %b", bus.mem_we_o, 1'b0); end
        $display("test_exec_wb done");
    endtask

    task automatic test_back_to_back;
        idle();
        bus.mem_rdata_i   = 32'h0000_0013;
        bus.ir_write_i    = 1'b1;
        bus.alu_src_b_i   = 2'b10;
        bus.result_src_i  = 2'b10;
        bus.pc_write_i    = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (bus.mem_addr_o !== 32'h8) begin errors++; $display("FAIL b2b_pc got %h want %h", bus.mem_addr_o, 32'h8); end
        show_alu(2'b01, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h4) begin errors++; $display("FAIL b2b_oldpc got %h want %h", bus.mem_addr_o, 32'h4); end
        idle();
        $display("test_back_to_back done");
    endtask

    task automatic test_x0;
        load_ir(addi(5'd0, 5'd0, 12'h055));
        bus.imm_src_i    = 3'b000;
        bus.result_src_i = 2'b11;
        bus.addr_src_i   = 1'b1;
        bus.reg_write_i  = 1'b1;
        #1;
        checks++; if (bus.mem_addr_o !== 32'h55) begin errors++; $display("FAIL x0_result got %h want %h", bus.mem_addr_o, 32'h55); end
        tick();
        idle();
        read_regs(5'd0, 5'd0);
        show_alu(2'b10, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL x0_read_a got %h want %h", bus.mem_addr_o, 32'h0); end
        checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL x0_read_b got %h want %h", bus.mem_wdata_o, 32'h0); end
        idle();
        $display("test_x0 done");
    endtask

    task automatic test_branch;
        write_reg(5'd2, 12'd7);
        write_reg(5'd3, 12'd8);
        read_regs(5'd2, 5'd2);
        show_alu(2'b10, 2'b00, 3'b001);
        checks++; if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL beq_equal got %b want %b", bus.zero_o, 1'b1); end
        read_regs(5'd2, 5'd3);
        show_alu(2'b10, 2'b00, 3'b001);
        checks++; if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL beq_differ got %b want %b", bus.zero_o, 1'b0); end
        checks++; if (bus.mem_addr_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_value got %h want %h", bus.mem_addr_o, 32'hFFFF_FFFF); end
        idle();
        $display("test_branch done");
    endtask

    task automatic test_alu_ops;
        logic [2:0]  ops  [7];
        logic [31:0] exps [7];
        ops  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b100, 3'b111};
        exps = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
`ifdef DATAPATH_SLT_EN
        exps[4] = 32'h1;
`endif
        write_reg(5'd4, 12'hFFF);
        write_reg(5'd5, 12'h001);
        read_regs(5'd4, 5'd5);
        for (int k = 0; k < 7; k++) begin
            show_alu(2'b10, 2'b00, ops[k]);
            checks++; if (bus.mem_addr_o !== exps[k]) begin errors++; $display("FAIL alu_op%0b got %h want %h", ops[k], bus.mem_addr_o, exps[k]); end
        end
        show_alu(2'b10, 2'b00, 3'b000);
        checks++; if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL add_wrap_zero got %b want %b", bus.zero_o, 1'b1); end
        idle();
        $display("test_alu_ops done");
    endtask

    task automatic test_same_cycle;
        load_ir(addi(5'd6, 5'd6, 12'h033));
        bus.imm_src_i    = 3'b000;
        bus.result_src_i = 2'b11;
        bus.reg_write_i  = 1'b1;
        tick();
        idle();
        show_alu(2'b10, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rw_old got %h want %h", bus.mem_addr_o, 32'h0); end
        tick();
        checks++; if (bus.mem_addr_o !== 32'h33) begin errors++; $display("FAIL rw_new got %h want %h", bus.mem_addr_o, 32'h33); end
        idle();
        $display("test_same_cycle done");
    endtask

    task automatic test_imm;
        logic [31:0] exps [8];
        exps = '{32'hFFFF_FF0F, 32'hFFFF_FF01, 32'hFFFF_FF00, 32'hFFF0_FF0E,
                 32'hF0F0_F000, 32'h0, 32'h0, 32'h0};
        load_ir(32'hF0F0_F0F0);
        #1;
        checks++; if (bus.op_o !== 7'h70) begin errors++; $display("FAIL imm_op got %h want %h", bus.op_o, 7'h70); end
        checks++; if ({bus.funct3_o, bus.funct7_o} !== 4'hF) begin errors++; $display("FAIL imm_funct got %h want %h", {bus.funct3_o, bus.funct7_o}, 4'hF); end
        bus.result_src_i = 2'b11;
        bus.addr_src_i   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.imm_src_i = 3'(k);
            #1;
            checks++; if (bus.mem_addr_o !== exps[k]) begin errors++; $display("FAIL imm_fmt%0d got %h want %h", k, bus.mem_addr_o, exps[k]); end
        end
        idle();
        $display("test_imm done");
    endtask

    task automatic test_reset_mid;
        load_ir(addi(5'd1, 5'd0, 12'h077));
        #1;
        checks++; if (bus.mem_addr_o !== 32'h8) begin errors++; $display("FAIL mid_pc_before got %h want %h", bus.mem_addr_o, 32'h8); end
        bus.imm_src_i    = 3'b000;
        bus.result_src_i = 2'b11;
        bus.reg_write_i  = 1'b1;
        bus.pc_write_i   = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_pc_async got %h want %h", bus.mem_addr_o, 32'h0); end
        checks++; if (bus.op_o !== 7'h0) begin errors++; $display("FAIL mid_op got %h want %h", bus.op_o, 7'h0); end
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        read_regs(5'd1, 5'd2);
        show_alu(2'b10, 2'b11, 3'b000);
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_x1 got %h want %h", bus.mem_addr_o, 32'h0); end
        checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL mid_x2 got %h want %h", bus.mem_wdata_o, 32'h0); end
        idle();
        #1;
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_pc_after got %h want %h", bus.mem_addr_o, 32'h0); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_exec_wb();
        test_back_to_back();
        test_x0();
        test_branch();
        test_alu_ops();
        test_same_cycle();
        test_imm();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
